// File: rtl/irrigation_scheduler_if.sv
// rtl/irrigation_scheduler_if.sv - request/release/grant bundle between requesters and the scheduler
interface irrigation_scheduler_if;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] grant;

    modport master (
        output req,
        output done,
        input  grant
    );

    modport slave (
        input  req,
        input  done,
        output grant
    );
endinterface

// File: rtl/irrigation_scheduler.sv
// rtl/irrigation_scheduler.sv - reservoir outflow time-slot scheduler; macro AGRO_PRIORITY_EN lets agro bypass round-robin
module irrigation_scheduler #(
    parameter int MAX_ON_S       = 30,
    parameter int GAP_S          = 5,
    parameter int FILL_TIMEOUT_S = 60
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    irrigation_scheduler_if.slave   bus,
    input  logic [1:0]              nivel,
    input  logic                    erro_nivel,
    output logic                    Ve,
    output logic [2:0]              state,
    output logic [5:0]              seg_restantes,
    output logic                    fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_FILL  = 3'b001,
        S_GRANT = 3'b010,
        S_GAP   = 3'b011,
        S_FAULT = 3'b100
    } state_t;

    state_t     st;
    logic [1:0] rr_ptr;
    logic [2:0] lvl_ok;
    logic [2:0] elig;
    logic       win_any;
    logic [1:0] win_idx;
    logic [2:0] win_oh;
    logic [1:0] c0, c1, c2;
    logic       timer_expire;
    logic       grant_end;

    function automatic logic [1:0] next3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign lvl_ok       = {nivel == 2'b11, nivel[1], nivel != 2'b00};
    assign elig         = bus.req & lvl_ok;
    assign timer_expire = tick && (seg_restantes == 6'd1);
    // the holder is whoever owns the grant bit, so non-holder done bits fall out naturally
    assign grant_end    = |(bus.grant & (bus.done | ~bus.req | ~lvl_ok));
    assign state        = st;

    always_comb begin
        c0      = next3(rr_ptr);
        c1      = next3(c0);
        c2      = next3(c1);
        win_any = |elig;
        win_idx = 2'd0;
        if (elig[c2]) win_idx = c2;
        if (elig[c1]) win_idx = c1;
        if (elig[c0]) win_idx = c0;
`ifdef AGRO_PRIORITY_EN
        if (elig[2]) win_idx = 2'd2;
`endif
        win_oh = 3'b001 << win_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st            <= S_IDLE;
            bus.grant     <= 3'b000;
            Ve            <= 1'b0;
            seg_restantes <= 6'd0;
            fault         <= 1'b0;
            rr_ptr        <= 2'd2;
        end else begin
            case (st)
                S_IDLE: begin
                    if (erro_nivel) begin
                        st            <= S_FAULT;
                        bus.grant     <= 3'b000;
                        Ve            <= 1'b0;
                        seg_restantes <= 6'd0;
                        fault         <= 1'b1;
                    end else if (win_any) begin
                        st            <= S_GRANT;
                        bus.grant     <= win_oh;
                        Ve            <= 1'b0;
                        seg_restantes <= 6'(MAX_ON_S);
`ifdef AGRO_PRIORITY_EN
                        if (!elig[2]) rr_ptr <= win_idx;
`else
                        rr_ptr        <= win_idx;
`endif
                    end else if (|bus.req) begin
                        st            <= S_FILL;
                        bus.grant     <= 3'b000;
                        Ve            <= 1'b1;
                        seg_restantes <= 6'(FILL_TIMEOUT_S);
                    end else begin
                        bus.grant     <= 3'b000;
                        Ve            <= 1'b0;
                        seg_restantes <= 6'd0;
                    end
                end

                S_FILL: begin
                    if (erro_nivel || timer_expire && nivel != 2'b11) begin
                        st            <= S_FAULT;
                        bus.grant     <= 3'b000;
                        Ve            <= 1'b0;
                        seg_restantes <= 6'd0;
                        fault         <= 1'b1;
                    end else if (nivel == 2'b11 || bus.req == 3'b000) begin
                        st            <= S_IDLE;
                        Ve            <= 1'b0;
                        seg_restantes <= 6'd0;
                    end else if (tick) begin
                        seg_restantes <= seg_restantes - 6'd1;
                    end
                end

                S_GRANT: begin
                    if (erro_nivel) begin
                        st            <= S_FAULT;
                        bus.grant     <= 3'b000;
                        Ve            <= 1'b0;
                        seg_restantes <= 6'd0;
                        fault         <= 1'b1;
                    end else if (grant_end || timer_expire) begin
                        st            <= S_GAP;
                        bus.grant     <= 3'b000;
                        seg_restantes <= 6'(GAP_S);
                    end else if (tick) begin
                        seg_restantes <= seg_restantes - 6'd1;
                    end
                end

                S_GAP: begin
                    if (erro_nivel) begin
                        st            <= S_FAULT;
                        bus.grant     <= 3'b000;
                        Ve            <= 1'b0;
                        seg_restantes <= 6'd0;
                        fault         <= 1'b1;
                    end else if (timer_expire) begin
                        st            <= S_IDLE;
                        seg_restantes <= 6'd0;
                    end else if (tick) begin
                        seg_restantes <= seg_restantes - 6'd1;
                    end
                end

                S_FAULT: begin
                    bus.grant     <= 3'b000;
                    Ve            <= 1'b0;
                    seg_restantes <= 6'd0;
                    fault         <= 1'b1;
                end

                default: begin
                    st            <= S_IDLE;
                    bus.grant     <= 3'b000;
                    Ve            <= 1'b0;
                    seg_restantes <= 6'd0;
                end
            endcase
        end
    end

endmodule
